// File: rtl/imem_boot_ctrl.sv
// Boot sequencer for the 64x32 instruction memory: clears every word, packs a
// little-endian byte stream into words, then releases the core's fetch path.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [WIDX_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [ADDR_W-1:0] core_fetch_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              core_stall,
  output logic              load_done,
  output logic [6:0]        words_loaded
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, RUN} state_t;

  localparam logic [6:0]        DEPTH_CNT = 7'(DEPTH);
  localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [WIDX_W-1:0] clr_idx;
  logic [1:0]        lane;
  logic [23:0]       word_lo;
  logic [6:0]        word_target;
  logic              accept;
  logic              restart;
  logic              last_byte;

  assign accept    = byte_ready & byte_valid;
  assign restart   = start && ((state == IDLE) || (state == RUN));
  assign last_byte = accept && (lane == 2'd3) && ((words_loaded + 7'd1) == word_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) state_nxt = LOAD;
      LOAD:    if (last_byte) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      RUN:     if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_raddr  = '0;
    case (state)
      LOAD:    byte_ready = 1'b1;
      RUN:     mem_raddr  = core_fetch_addr;
      default: ;
    endcase
  end

  // Registered outputs are loaded with the values for the cycle being entered,
  // so clear index k and each assembled word appear on the port in their own cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_stall   <= 1'b1;
      load_done    <= 1'b0;
      words_loaded <= '0;
      lane         <= '0;
      word_lo      <= '0;
      word_target  <= '0;
      clr_idx      <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (restart) begin
        word_target  <= ((num_words == '0) || (num_words > DEPTH_CNT)) ? DEPTH_CNT : num_words;
        clr_idx      <= '0;
        mem_we       <= 1'b1;
        mem_waddr    <= '0;
        mem_wdata    <= '0;
        core_stall   <= 1'b1;
        words_loaded <= '0;
        lane         <= '0;
        word_lo      <= '0;
      end else if ((state == CLEAR) && (clr_idx != LAST_IDX)) begin
        clr_idx   <= clr_idx + 1'b1;
        mem_we    <= 1'b1;
        mem_waddr <= clr_idx + 1'b1;
        mem_wdata <= '0;
      end else if (accept) begin
        lane <= lane + 1'b1;
        case (lane)
          2'd0: word_lo[7:0]   <= byte_data;
          2'd1: word_lo[15:8]  <= byte_data;
          2'd2: word_lo[23:16] <= byte_data;
          default: begin
            mem_we       <= 1'b1;
            mem_waddr    <= words_loaded[WIDX_W-1:0];
            mem_wdata    <= {byte_data, word_lo};
            words_loaded <= words_loaded + 7'd1;
          end
        endcase
      end else if (state == FLUSH) begin
        core_stall <= 1'b0;
        load_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: cycle/byte-count reference model compared every
// cycle, plus a memory image rebuilt from the observed writes.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic [7:0]  core_fetch_addr = '0;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_raddr;
  logic        core_stall;
  logic        load_done;
  logic [6:0]  words_loaded;

  imem_boot_ctrl #(.DEPTH(64), .ADDR_W(8), .WIDX_W(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_words       (num_words),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .core_fetch_addr (core_fetch_addr),
    .mem_raddr       (mem_raddr),
    .core_stall      (core_stall),
    .load_done       (load_done),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 waiting, 1 boot sequence, 2 core running.
  // Within the sequence, the first 64 cycles clear; then bytes are taken until 4n
  // have arrived; the one cycle after that is the final-word flush.
  int          m_phase, m_cyc, m_bytes, m_n;
  logic [7:0]  m_buf [4];
  logic        e_we, e_stall, e_done;
  logic [5:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [6:0]  e_words;

  function automatic bit m_loading();
    return (m_phase == 1) && (m_cyc >= 64) && (m_bytes < 4 * m_n);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cyc = 0; m_bytes = 0; m_n = 0;
    e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_stall = 1'b1; e_done = 1'b0; e_words = '0;
  endtask

  task automatic model_step();
    bit loading, flushing;
    loading  = m_loading();
    flushing = (m_phase == 1) && (m_cyc >= 64) && (m_bytes == 4 * m_n);
    e_we   = 1'b0;
    e_done = 1'b0;
    if (m_phase != 1) begin
      if (start) begin
        m_phase = 1; m_cyc = 0; m_bytes = 0;
        m_n = ((num_words == 0) || (num_words > 64)) ? 64 : int'(num_words);
        e_we = 1'b1; e_waddr = '0; e_wdata = '0; e_stall = 1'b1; e_words = '0;
      end
    end else begin
      if (m_cyc < 63) begin
        e_we = 1'b1; e_waddr = 6'(m_cyc + 1); e_wdata = '0;
      end
      if (loading && byte_valid) begin
        m_buf[m_bytes % 4] = byte_data;
        m_bytes++;
        if (m_bytes % 4 == 0) begin
          e_we    = 1'b1;
          e_waddr = 6'(m_bytes / 4 - 1);
          e_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          e_words = 7'(m_bytes / 4);
        end
      end
      if (flushing) begin
        m_phase = 2; e_done = 1'b1; e_stall = 1'b0;
      end
      m_cyc++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus write capture into a memory image.
  logic [31:0] img [64];
  logic [37:0] wq [$];
  int          wr_count = 0;
  int          ready_cycles = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("mem_we", mem_we, e_we);
      chk("core_stall", core_stall, e_stall);
      chk("load_done", load_done, e_done);
      chk("words_loaded", words_loaded, e_words);
      chk("byte_ready", byte_ready, m_loading());
      chk("mem_raddr", mem_raddr, (m_phase == 2) ? core_fetch_addr : 8'h00);
      if (e_we || !rst_n) begin
        chk("mem_waddr", mem_waddr, e_waddr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (rst_n && mem_we) begin
        img[mem_waddr] = mem_wdata;
        wr_count++;
        wq.push_back({mem_waddr, mem_wdata});
      end
      if (byte_ready) ready_cycles++;
    end
  end

  logic [7:0] prog [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_prog(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog[i] = 8'($urandom);
  endtask

  task automatic do_start(input logic [6:0] nw, input bit hold);
    for (int i = 0; i < 64; i++) img[i] = 32'hDEAD_0000 | 32'(i);
    wr_count = 0;
    ready_cycles = 0;
    wq.delete();
    num_words = nw;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    num_words = 7'($urandom);
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps
  task automatic feed(input int nbytes, input int mode);
    int   pos;
    int   budget;
    bit   tog;
    bit   v;
    logic rdy;
    pos = 0; budget = 64 + 8 * nbytes + 40; tog = 1'b0;
    while (pos < nbytes && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data = prog[pos];
      core_fetch_addr = 8'($urandom);
      rdy = byte_ready;
      tick();
      if (v && rdy) pos++;
      tog = !tog;
      budget--;
    end
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
    chk("feed_complete", pos, nbytes);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (load_done !== 1'b1 && i < 16) begin
      tick();
      i++;
    end
    chk("done_seen", load_done, 1);
    chk("stall_at_done", core_stall, 0);
  endtask

  task automatic check_image(input int n);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = (i < n) ? {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]} : 32'h0;
      chk($sformatf("img[%0d]", i), img[i], w);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", core_stall, 1);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", byte_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed so far", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t1;
    t1 = 64'h00A585B3_00500513;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_stall", core_stall, 1);
    chk("init_we", mem_we, 0);
    chk("init_waddr", mem_waddr, 0);
    chk("init_wdata", mem_wdata, 0);
    chk("init_words", words_loaded, 0);
    chk("init_ready", byte_ready, 0);
    chk("init_raddr", mem_raddr, 0);

    // 1: two-word program, back-to-back bytes
    for (int i = 0; i < 8; i++) prog[i] = t1[8*i +: 8];
    do_start(7'd2, 1'b0);
    feed(8, 0);
    wait_done();
    chk("t1_writes", wr_count, 66);
    if (wq.size() == 66) begin
      chk("t1_w0_addr", 32'(wq[64][37:32]), 0);
      chk("t1_w0_data", wq[64][31:0], 32'h00500513);
      chk("t1_w1_addr", 32'(wq[65][37:32]), 1);
      chk("t1_w1_data", wq[65][31:0], 32'h00A585B3);
    end
    chk("t1_words", words_loaded, 2);
    check_image(2);

    // 2: fetch pass-through, bytes refused while running
    core_fetch_addr = 8'h04;
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    #1;
    chk("t2_raddr", mem_raddr, 8'h04);
    chk("t2_ready", byte_ready, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      core_fetch_addr = 8'($urandom);
    end
    byte_valid = 1'b0;
    chk("t2_writes", wr_count, 66);

    // 3: one word with alternating byte_valid
    do_start(7'd1, 1'b0);
    feed(4, 1);
    wait_done();
    chk("t3_load_cycles", ready_cycles, 8);
    chk("t3_writes", wr_count, 65);
    if (wq.size() == 65) chk("t3_w0_data", wq[64][31:0], 32'h00500513);
    check_image(1);

    // 4: reset mid-clear and mid-load, then a clean load
    fill_prog(8);
    do_start(7'd2, 1'b0);
    repeat (30) tick();
    chk("t4_clear_idx", mem_waddr, 30);
    pulse_reset();
    do_start(7'd2, 1'b0);
    feed(2, 0);
    pulse_reset();
    fill_prog(8);
    do_start(7'd2, 1'b0);
    feed(8, 2);
    wait_done();
    chk("t4_writes", wr_count, 66);
    check_image(2);

    // 5: num_words=0 loads the full depth, then restart from run
    fill_prog(256);
    do_start(7'd0, 1'b0);
    feed(256, 2);
    wait_done();
    chk("t5_words", words_loaded, 64);
    chk("t5_writes", wr_count, 128);
    check_image(64);

    // 6: restart from run with start held through clear and load
    fill_prog(20);
    do_start(7'd5, 1'b1);
    chk("t5_restart_stall", core_stall, 1);
    chk("t5_restart_we", mem_we, 1);
    chk("t5_restart_waddr", mem_waddr, 0);
    chk("t5_restart_wdata", mem_wdata, 0);
    chk("t5_restart_words", words_loaded, 0);
    feed(20, 2);
    start = 1'b0;
    wait_done();
    chk("t6_writes", wr_count, 69);
    check_image(5);

    // num_words above depth is capped
    fill_prog(256);
    do_start(7'd100, 1'b0);
    feed(256, 0);
    wait_done();
    chk("cap_words", words_loaded, 64);
    check_image(64);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
